// File: rtl/uart_pkg.sv
// Shared UART types: receiver FSM state plus the CFG/INTR register layouts.
// Also holds the parity check used by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_rx_state_t;

    typedef struct packed {
        logic extra_stop_bits;
        logic parity_type;
        logic parity_en;
    } uart_cfg_t;

    typedef struct packed {
        logic rx_overflow;
        logic rx_valid;
        logic tx_empty;
    } uart_intr_t;

    // odd = 0 expects an even count of ones over data plus parity bit
    function automatic logic parity_err(input logic [7:0] data, input logic p, input logic odd);
        return ((^data) ^ p) != odd;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a configurable reset value.
// q_next_o exposes the first stage so a consumer can see the next synchronized value one cycle early.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o,
    output logic q_next_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o      = r_sync;
    assign q_next_o = r_meta;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampling-free mid-bit sampler feeding a one-entry valid/ready output register.
// Optional macro UART_RX_FRAME_ERR_EN adds frame_error_o (any sampled stop bit low).
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic        clk_en_i,
    input  logic [31:0] clk_div_i,
    input  logic        parity_en_i,
    input  logic        parity_type_i,
    input  logic        extra_stop_bits_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        parity_error_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overflow_o
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic        frame_error_o
`endif
);

    logic w_rx;
    logic w_rx_next;
    logic w_fall;
    logic w_expired;
    logic w_complete;
    logic w_accept;

    uart_rx_state_t r_state;
    logic [31:0]    r_timer;
    logic [2:0]     r_idx;
    logic [7:0]     r_shift;
    logic           r_par_err;
    logic [7:0]     r_data;
    logic           r_parity_error;
    logic           r_valid;
    logic           r_overflow;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i    (clk_i),
        .arst_ni  (arst_ni),
        .d_i      (rx_i),
        .q_o      (w_rx),
        .q_next_o (w_rx_next)
    );

    // The edge is seen as it enters the synchronized line, so a timer load of
    // div>>1 lands the start-bit sample at bit centre (first cycle when div = 0).
    assign w_fall     = w_rx & ~w_rx_next;
    assign w_expired  = (r_timer == 32'd0);
    assign w_complete = clk_en_i && (r_state != ST_IDLE) && w_expired &&
                        (((r_state == ST_STOP1) && !extra_stop_bits_i) || (r_state == ST_STOP2));
    assign w_accept   = ~r_valid | ready_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else if (!clk_en_i) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_fall) begin
                r_state <= ST_START;
                r_timer <= clk_div_i >> 1;
            end
        end else if (!w_expired) begin
            r_timer <= r_timer - 32'd1;
        end else begin
            r_timer <= clk_div_i;
            case (r_state)
                ST_START: begin
                    r_state <= w_rx ? ST_IDLE : ST_DATA;
                    r_idx   <= '0;
                end
                ST_DATA: begin
                    r_shift[r_idx] <= w_rx;
                    r_idx          <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        r_state   <= parity_en_i ? ST_PARITY : ST_STOP1;
                        r_par_err <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    r_par_err <= parity_err(r_shift, w_rx, parity_type_i);
                    r_state   <= ST_STOP1;
                end
                ST_STOP1: r_state <= extra_stop_bits_i ? ST_STOP2 : ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // A completed byte that cannot be stored is dropped; the held byte wins.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_data         <= '0;
            r_parity_error <= 1'b0;
            r_valid        <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_overflow <= w_complete & ~w_accept;
            if (w_complete && w_accept) begin
                r_data         <= r_shift;
                r_parity_error <= r_par_err;
                r_valid        <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o         = r_data;
    assign parity_error_o = r_parity_error;
    assign valid_o        = r_valid;
    assign overflow_o     = r_overflow;

`ifdef UART_RX_FRAME_ERR_EN
    logic r_frm_acc;
    logic r_frame_err;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_frm_acc   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_state == ST_START) begin
                r_frm_acc <= 1'b0;
            end else if (clk_en_i && w_expired && !w_rx &&
                         ((r_state == ST_STOP1) || (r_state == ST_STOP2))) begin
                r_frm_acc <= 1'b1;
            end
            if (w_complete && w_accept) begin
                r_frame_err <= r_frm_acc | ~w_rx;
            end
        end
    end

    assign frame_error_o = r_frame_err;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
// Builds with or without UART_RX_FRAME_ERR_EN.
module tb_uart_rx;

    logic        clk;
    logic        arst_n;
    logic        clk_en;
    logic [31:0] div;
    logic        parity_en;
    logic        parity_type;
    logic        extra_stop;
    logic        rx;
    logic [7:0]  data;
    logic        perr;
    logic        valid;
    logic        ready;
    logic        overflow;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ovf_cnt  = 0;
    int rise_cyc = -1;
    int start_cyc = 0;
    logic valid_prev = 1'b0;
    logic [9:0] rx_q[$];

    uart_rx dut (
        .clk_i             (clk),
        .arst_ni           (arst_n),
        .clk_en_i          (clk_en),
        .clk_div_i         (div),
        .parity_en_i       (parity_en),
        .parity_type_i     (parity_type),
        .extra_stop_bits_i (extra_stop),
        .rx_i              (rx),
        .data_o            (data),
        .parity_error_o    (perr),
        .valid_o           (valid),
        .ready_i           (ready),
        .overflow_o        (overflow)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_error_o     (frame_err)
`endif
    );

`ifndef UART_RX_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every accepted byte, overflow pulses and valid rising edges
    always @(negedge clk) begin
        if (valid && ready) rx_q.push_back({frame_err, perr, data});
        if (overflow) ovf_cnt++;
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(int'(div) + 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                              input logic two, input logic pbit, input logic s1, input logic s2);
        parity_en   = pen;
        parity_type = ptype;
        extra_stop  = two;
        start_cyc   = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rx = 1'b1;
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic pen, input logic ptype, input logic pbit);
        int ones;
        if (!pen) return 1'b0;
        ones = $countones(d) + int'(pbit);
        return (ones % 2) != int'(ptype);
    endfunction

    function automatic logic model_ferr(input logic two, input logic s1, input logic s2);
`ifdef UART_RX_FRAME_ERR_EN
        return !s1 || (two && !s2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pen, input logic ptype,
                                input logic two, input logic pbit, input logic s1, input logic s2);
        logic [9:0] got;
        rx_q.delete();
        send_frame(d, pen, ptype, two, pbit, s1, s2);
        tick(2 * (int'(div) + 1) + 6);
        check_eq({tag, "_count"}, rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            check_eq({tag, "_data"}, {24'd0, got[7:0]}, {24'd0, d});
            check_eq({tag, "_perr"}, {31'd0, got[8]}, {31'd0, model_perr(d, pen, ptype, pbit)});
            check_eq({tag, "_ferr"}, {31'd0, got[9]}, {31'd0, model_ferr(two, s1, s2)});
            $display("frame %s div=%0d byte=%02h pen=%0d odd=%0d pbit=%0d stops=%0d%0d%0d -> data=%02h perr=%0d ferr=%0d",
                     tag, div, d, pen, ptype, pbit, two, s1, s2, got[7:0], got[8], got[9]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd;
        logic       rpen, rodd, rtwo, rpbit, rs1, rs2;

        arst_n = 1'b0; clk_en = 1'b1; div = 32'd3; parity_en = 1'b0; parity_type = 1'b0;
        extra_stop = 1'b0; rx = 1'b1; ready = 1'b1;
        tick(3);
        check_eq("rst_valid", {31'd0, valid}, 0);
        check_eq("rst_data", {24'd0, data}, 0);
        check_eq("rst_perr", {31'd0, perr}, 0);
        check_eq("rst_ovf", {31'd0, overflow}, 0);
        arst_n = 1'b1;
        tick(4);

        // 8N1 at div=3 with latency: 2 sync cycles + ~38 from the synchronized edge
        rise_cyc = -1;
        expect_frame("a5_8n1", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("a5_latency_ok", {31'd0, (rise_cyc - start_cyc >= 38) && (rise_cyc - start_cyc <= 42)}, 1);

        expect_frame("par_even_p0", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame("par_even_p1", 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_frame("par_odd_p0",  8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // One-cycle low glitch at div=7 must be rejected
        div = 32'd7; parity_en = 1'b0; rx_q.delete();
        rx = 1'b0; tick(1); rx = 1'b1;
        tick(40);
        check_eq("glitch_count", rx_q.size(), 0);
        check_eq("glitch_valid", {31'd0, valid}, 0);
        $display("glitch div=7 -> accepted=%0d valid=%0d", rx_q.size(), valid);

        // Back-pressure: second byte dropped with one overflow pulse
        div = 32'd3; ready = 1'b0; ovf_cnt = 0; rx_q.delete();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick(10);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick(10);
        check_eq("ovf_data", {24'd0, data}, 32'h11);
        check_eq("ovf_valid", {31'd0, valid}, 1);
        check_eq("ovf_pulses", ovf_cnt, 1);
        ready = 1'b1; tick(1);
        check_eq("ovf_valid_drop", {31'd0, valid}, 0);
        check_eq("ovf_accepted", rx_q.size(), 1);
        if (rx_q.size() > 0) check_eq("ovf_accepted_data", {24'd0, rx_q[0][7:0]}, 32'h11);
        $display("overflow 11,22 ready=0 -> held=%02h pulses=%0d", data, ovf_cnt);

        // Reset in the middle of a frame while a byte is held
        ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick(10);
        fork
            send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                tick(2 + 5 * (int'(div) + 1) + 2);
                arst_n = 1'b0;
                #1;
                check_eq("midrst_valid", {31'd0, valid}, 0);
                check_eq("midrst_data", {24'd0, data}, 0);
                check_eq("midrst_perr", {31'd0, perr}, 0);
                check_eq("midrst_ovf", {31'd0, overflow}, 0);
            end
        join
        tick(2); arst_n = 1'b1; ready = 1'b1; rx_q.delete();
        tick(20);
        check_eq("postrst_count", rx_q.size(), 0);
        $display("reset mid-frame 5A -> valid=%0d data=%02h", valid, data);
        expect_frame("post_rst_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Clock-enable drop mid-frame aborts silently
        rx_q.delete();
        fork
            send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            begin tick(15); clk_en = 1'b0; end
        join
        tick(3); clk_en = 1'b1; tick(10);
        check_eq("clken_count", rx_q.size(), 0);
        check_eq("clken_valid", {31'd0, valid}, 0);
        $display("clk_en abort 99 -> accepted=%0d", rx_q.size());

`ifdef UART_RX_FRAME_ERR_EN
        div = 32'd3;
        expect_frame("ferr_stop2", 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

        // Fastest rate: one clock per bit
        div = 32'd0;
        expect_frame("div0", 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            div   = $urandom_range(0, 6);
            rd    = 8'($urandom);
            rpen  = 1'($urandom);
            rodd  = 1'($urandom);
            rtwo  = 1'($urandom);
            rpbit = 1'($urandom);
            rs1   = ($urandom_range(0, 3) != 0);
            rs2   = ($urandom_range(0, 3) != 0);
            expect_frame($sformatf("rnd%0d", n), rd, rpen, rodd, rtwo, rpbit, rs1, rs2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter none; all configuration arrives on ports, with defaults held by the register block.
REQ-002 SHALL have port `clk_i`, input, 1 bit: the single APB clock; all logic is on its rising edge.
REQ-003 SHALL have port `arst_ni`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `clk_en_i`, input, 1 bit: CTRL.CLK_EN; when 0, the receiver is held in IDLE.
REQ-005 SHALL have port `clk_div_i`, input, 32 bits: CLK_DIV; bit period = `clk_div_i`+1 clocks.
REQ-006 SHALL have port `parity_en_i`, input, 1 bit: CFG.PARITY_EN.
REQ-007 SHALL have port `parity_type_i`, input, 1 bit: CFG.PARITY_TYPE; 0 = even, 1 = odd.
REQ-008 SHALL have port `extra_stop_bits_i`, input, 1 bit: CFG.EXTRA_STOP_BITS; 1 = two stop bits.
REQ-009 SHALL have port `rx_i`, input, 1 bit: asynchronous serial line; idles high.
REQ-010 SHALL have port `data_o`, output, 8 bits: received byte, LSB first on the line.
REQ-011 SHALL have port `parity_error_o`, output, 1 bit: parity mismatch flag for `data_o`.
REQ-012 SHALL have port `valid_o`, output, 1 bit: byte available for the RX FIFO.
REQ-013 SHALL have port `ready_i`, input, 1 bit: RX FIFO accepts; transfer occurs when `valid_o` && `ready_i`.
REQ-014 SHALL have port `overflow_o`, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-015 SHALL pass `rx_i` through a 2-flop synchronizer reset to 1; all sampling uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 with a 32-bit bit-timer and a 3-bit bit index.
REQ-017 In IDLE, a synchronized falling edge SHALL move to START and load the timer with `clk_div_i`>>1.
REQ-018 In START, at timer expiry the line SHALL be sampled: low moves to DATA with the timer reloaded to `clk_div_i`; high returns to IDLE as a glitch.
REQ-019 In DATA, one bit SHALL be sampled per timer expiry into bit position index, LSB first; after bit 7 the FSM moves to PARITY if `parity_en_i`, else STOP1.
REQ-020 In PARITY, the sampled bit p SHALL give parity error = (^data ^ p) != `parity_type_i`; when parity is disabled, the error SHALL be 0.
REQ-021 In STOP1, at expiry the FSM SHALL go to STOP2 if `extra_stop_bits_i`, else complete; STOP2 completes at its expiry.
REQ-022 Stop-bit values SHALL NOT abort the frame; the FSM returns to IDLE on completion.
REQ-023 On completion, if `valid_o` is 0 or `ready_i` is 1, `data_o`/`parity_error_o` SHALL load and `valid_o` SHALL assert the next cycle; otherwise the new byte is dropped, the held byte is kept and `overflow_o` pulses.
REQ-024 `valid_o` SHALL clear the cycle after a handshake unless a byte completes in that same cycle, in which case it stays high with the new data.
REQ-025 Configuration inputs SHALL be sampled only at the point of use; changes mid-frame affect subsequent bits only.
REQ-026 `clk_en_i` falling to 0 mid-frame SHALL abort to IDLE without emitting; the output register is unaffected.
REQ-027 With `clk_div_i` = 0, every clock SHALL be one bit period and START SHALL sample immediately.

Reset
REQ-028 Reset SHALL set state IDLE, timer 0, index 0, synchronizer 1, `data_o` 0, `parity_error_o` 0, `valid_o` 0, `overflow_o` 0.
REQ-029 Reset asserted mid-frame SHALL abort immediately; after release, no byte is emitted until a new start bit.

Configuration
REQ-030 The macro UART_RX_FRAME_ERR_EN SHALL add an output `frame_error_o`, registered with `data_o`, set if any sampled stop bit is 0.
REQ-031 Without UART_RX_FRAME_ERR_EN, the `frame_error_o` port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 The FSM state enum `uart_rx_state_t` SHALL live in the shared UART package, alongside the existing CFG/INTR register types.
REQ-033 The synchronizer SHALL be a sub-module `uart_sync` (2-flop, reset value parameter); no other sub-modules.

Verification
REQ-034 Div=3, 8N1, byte 0xA5 -> `valid_o` rises with `data_o`=0xA5, `parity_error_o`=0; this happens 1 cycle after the STOP1 sample, ~38 cycles after the start edge.
REQ-035 Div=3, even parity, 0x07, parity bit 0 -> `parity_error_o`=1; with parity bit 1 -> 0; odd parity, 0x07, parity bit 0 -> 0.
REQ-036 Low pulse of 1 cycle at div=7 -> FSM returns to IDLE, `valid_o` stays 0.
REQ-037 `ready_i`=0, two frames 0x11 then 0x22 -> `data_o` stays 0x11 and `overflow_o` pulses once; then `ready_i`=1 -> `valid_o` drops.
REQ-038 `arst_ni` low during DATA bit 4 -> all outputs 0; next full frame 0x3C is received correctly.
REQ-039 With UART_RX_FRAME_ERR_EN, two stop bits, second stop bit 0 -> `frame_error_o`=1 with `data_o` valid.
